glitch_free_nmux: RTL and testbench

- N-input glitch-free clock multiplexer; parametrised successor of the team's 2-input clock switch.
- Control FSM runs in the clk0_inv domain and accepts select requests through a valid/ready handshake.
- Per-channel enable/acknowledge synchronisers guarantee break-before-make switching: the old clock is gated off at its low phase before the new clock is gated on.
- Sits at the clock-generation top, feeding a downstream clock tree.

---
 rtl/glitch_free_pkg.sv | 18 +
 rtl/glitch_free_nmux_if.sv | 25 ++
 rtl/glitch_free_chan.sv | 61 ++++++
 rtl/glitch_free_nmux.sv | 177 +++++++++++++++++
 tb/tb_glitch_free_nmux.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/glitch_free_pkg.sv
// Shared types and helpers for the N-input glitch-free clock multiplexer.
package glitch_free_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOff,
    StOn,
    StDone
  } gf_state_e;

  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;

  function automatic int unsigned sel_width(input int unsigned n_clk);
    return (n_clk > 1) ? $clog2(n_clk) : 1;
  endfunction

endpackage

// File: rtl/glitch_free_nmux_if.sv
// Select-request handshake and status bundle between a requester and glitch_free_nmux.
interface glitch_free_nmux_if #(
  parameter int unsigned N_CLK = 4
) ();

  localparam int unsigned SelW = glitch_free_pkg::sel_width(N_CLK);

  logic [SelW-1:0] sel_req;
  logic            req_valid;
  logic            req_ready;
  logic            switch_done;
  logic            sel_err;
  logic [SelW-1:0] cur_sel;

  modport master (
    output sel_req, req_valid,
    input  req_ready, switch_done, sel_err, cur_sel
  );

  modport slave (
    input  sel_req, req_valid,
    output req_ready, switch_done, sel_err, cur_sel
  );

endinterface

// File: rtl/glitch_free_chan.sv
// One mux channel: enable synchroniser into the source domain, low-phase gate flop,
// clock AND gate and acknowledge synchroniser back to clk0_inv.
module glitch_free_chan #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic clk0_inv,
  input  logic reset,
  input  logic i_en_req,
  input  logic i_force_clr,
  output logic o_gate_en,
  output logic o_ack,
  output logic o_clk_gated
);

  logic [SYNC_STAGES-2:0] r_en_sync;
  logic                   r_gate_en;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  // Force-clear empties the whole enable path so a revived dead clock cannot re-gate.
  always_ff @(posedge i_clk or posedge reset or posedge i_force_clr) begin
    if (reset) begin
      r_en_sync <= {(SYNC_STAGES-1){RST_VAL}};
    end else if (i_force_clr) begin
      r_en_sync <= '0;
    end else begin
      r_en_sync[0] <= i_en_req;
      for (int k = 1; k < SYNC_STAGES - 1; k++) begin
        r_en_sync[k] <= r_en_sync[k-1];
      end
    end
  end

  // Negedge flop: the gate only moves while i_clk is low.
  always_ff @(negedge i_clk or posedge reset or posedge i_force_clr) begin
    if (reset) begin
      r_gate_en <= RST_VAL;
    end else if (i_force_clr) begin
      r_gate_en <= 1'b0;
    end else begin
      r_gate_en <= r_en_sync[SYNC_STAGES-2];
    end
  end

  always_ff @(posedge clk0_inv or posedge reset) begin
    if (reset) begin
      r_ack_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_ack_sync[0] <= r_gate_en;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_ack_sync[k] <= r_ack_sync[k-1];
      end
    end
  end

  assign o_gate_en   = r_gate_en;
  assign o_ack       = r_ack_sync[SYNC_STAGES-1];
  assign o_clk_gated = i_clk & r_gate_en;

endmodule

// File: rtl/glitch_free_nmux.sv
// N-input break-before-make clock multiplexer with a clk0_inv-domain switch FSM.
// Optional dead-clock timeout enabled by defining GLITCH_FREE_NMUX_TIMEOUT_EN.
module glitch_free_nmux
  import glitch_free_pkg::*;
#(
  parameter int unsigned N_CLK       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_SEL   = 0
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic               clk0_inv,
  input  logic               reset,
  input  logic [N_CLK-1:0]   i_clk_in,
  glitch_free_nmux_if.slave  bus,
  output logic               o_clko
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
  ,
  output logic               o_timeout_flag
`endif
);

  localparam int unsigned SEL_W = sel_width(N_CLK);
  localparam int unsigned SyncN = (SYNC_STAGES < SyncStagesMin) ? SyncStagesMin :
                                  (SYNC_STAGES > SyncStagesMax) ? SyncStagesMax : SYNC_STAGES;
  localparam logic [SEL_W-1:0] ResetSelW = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   NClkW     = (SEL_W+1)'(N_CLK);
  localparam logic [N_CLK-1:0] EnRst     = N_CLK'(1) << RESET_SEL;

  gf_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0] r_cur_sel, w_cur_sel_nxt;
  logic [SEL_W-1:0] r_tgt, w_tgt_nxt;
  logic [N_CLK-1:0] r_en_req, w_en_req_nxt;
  logic             r_noop_done, w_noop_done_nxt;
  logic             r_sel_err, w_sel_err_nxt;

  logic [N_CLK-1:0] w_gate_en;
  logic [N_CLK-1:0] w_ack;
  logic [N_CLK-1:0] w_clk_gated;
  logic [N_CLK-1:0] w_force_clr;

`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [N_CLK-1:0] r_force_clr, w_force_clr_nxt;

  assign w_force_clr    = r_force_clr;
  assign o_timeout_flag = r_timeout;
`else
  assign w_force_clr = '0;
`endif

  for (genvar i = 0; i < N_CLK; i++) begin : gen_chan
    glitch_free_chan #(
      .SYNC_STAGES (SyncN),
      .RST_VAL     (i == RESET_SEL)
    ) u_chan (
      .i_clk       (i_clk_in[i]),
      .clk0_inv    (clk0_inv),
      .reset       (reset),
      .i_en_req    (r_en_req[i]),
      .i_force_clr (w_force_clr[i]),
      .o_gate_en   (w_gate_en[i]),
      .o_ack       (w_ack[i]),
      .o_clk_gated (w_clk_gated[i])
    );
  end

  assign o_clko = |w_clk_gated;

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_sel_nxt   = r_cur_sel;
    w_tgt_nxt       = r_tgt;
    w_en_req_nxt    = r_en_req;
    w_noop_done_nxt = 1'b0;
    w_sel_err_nxt   = 1'b0;
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
    w_cnt_nxt       = (r_state == StOff || r_state == StOn) ? r_cnt + 1'b1 : '0;
    w_timeout_nxt   = 1'b0;
    w_force_clr_nxt = '0;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          if ({1'b0, bus.sel_req} >= NClkW) begin
            w_sel_err_nxt = 1'b1;
          end else if (bus.sel_req == r_cur_sel) begin
            w_noop_done_nxt = 1'b1;
          end else begin
            w_tgt_nxt               = bus.sel_req;
            w_en_req_nxt[r_cur_sel] = 1'b0;
            w_state_nxt             = StOff;
          end
        end
      end
      StOff: begin
        if (!w_ack[r_cur_sel]) begin
          w_en_req_nxt[r_tgt] = 1'b1;
          w_state_nxt         = StOn;
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
          w_cnt_nxt           = '0;
        end else if (r_cnt == CntLimit) begin
          // Old clock presumed dead: clear its gate locally and carry on.
          w_force_clr_nxt[r_cur_sel] = 1'b1;
          w_en_req_nxt[r_tgt]        = 1'b1;
          w_timeout_nxt              = 1'b1;
          w_cnt_nxt                  = '0;
          w_state_nxt                = StOn;
`endif
        end
      end
      StOn: begin
        if (w_ack[r_tgt]) begin
          w_cur_sel_nxt = r_tgt;
          w_state_nxt   = StDone;
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
        end else if (r_cnt == CntLimit) begin
          w_en_req_nxt[r_tgt] = 1'b0;
          w_sel_err_nxt       = 1'b1;
          w_timeout_nxt       = 1'b1;
          w_state_nxt         = StIdle;
`endif
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk0_inv or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cur_sel   <= ResetSelW;
      r_tgt       <= ResetSelW;
      r_en_req    <= EnRst;
      r_noop_done <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_sel   <= w_cur_sel_nxt;
      r_tgt       <= w_tgt_nxt;
      r_en_req    <= w_en_req_nxt;
      r_noop_done <= w_noop_done_nxt;
      r_sel_err   <= w_sel_err_nxt;
    end
  end

`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
  always_ff @(posedge clk0_inv or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_force_clr <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
      r_force_clr <= w_force_clr_nxt;
    end
  end
`endif

  assign bus.req_ready   = (r_state == StIdle);
  assign bus.switch_done = r_noop_done | (r_state == StDone);
  assign bus.sel_err     = r_sel_err;
  assign bus.cur_sel     = r_cur_sel;

endmodule

// File: tb/tb_glitch_free_nmux.sv
// Self-checking bench for glitch_free_nmux; five clocks so that selects 5..7 are out of range.
module tb_glitch_free_nmux;

  localparam int unsigned NClk = 5;

  typedef struct {
    logic       done;
    logic       err;
    logic [2:0] cur;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic       err;
    logic       done;
    logic [2:0] cur;
  } vec_t;

  logic clk0 = 1'b0, clk1 = 1'b0, clk2 = 1'b0, clk3 = 1'b0, clk4 = 1'b0;
  logic run1 = 1'b1;
  logic clk0_inv;
  logic reset;
  logic [NClk-1:0] clk_in;
  logic clko;

  int total = 0;
  int bad = 0;
  int short_cnt = 0;
  int long_cnt = 0;
  int multi_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[9];

  time  t_rise = 0;
  logic pulse_ok = 1'b0;

  assign clk0_inv = ~clk0;
  assign clk_in   = {clk4, clk3, clk2, clk1, clk0};

  always #50 clk0 = ~clk0;
  always #60 clk1 = run1 ? ~clk1 : 1'b0;
  always #35 clk2 = ~clk2;
  always #45 clk3 = ~clk3;
  always #80 clk4 = ~clk4;

  glitch_free_nmux_if #(.N_CLK(NClk)) bus ();

`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
  logic to_flag;
  int   to_cnt = 0;
`endif

  glitch_free_nmux #(
    .N_CLK       (NClk),
    .SYNC_STAGES (2),
    .RESET_SEL   (0)
  ) dut (
    .clk0_inv       (clk0_inv),
    .reset          (reset),
    .i_clk_in       (clk_in),
    .bus            (bus.slave),
    .o_clko         (clko)
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
    ,
    .o_timeout_flag (to_flag)
`endif
  );

  // High pulses must be a full half period of some source (35..80).
  always @(posedge clko or posedge reset) begin
    if (reset) begin
      pulse_ok <= 1'b0;
    end else begin
      t_rise   <= $time;
      pulse_ok <= 1'b1;
    end
  end

  always @(negedge clko) begin
    if (pulse_ok && !reset) begin
      if ($time - t_rise < 34) short_cnt <= short_cnt + 1;
      if ($time - t_rise > 81) long_cnt <= long_cnt + 1;
    end
  end

  always @(dut.w_gate_en) begin
    if (!reset && !$onehot0(dut.w_gate_en)) multi_cnt <= multi_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clk0_inv cycle; any done/err pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk0_inv);
    #1;
    if (bus.switch_done || bus.sel_err) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pulse: got done=%0b err=%0b want no pulse", bus.switch_done, bus.sel_err);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_done", bus.switch_done, e.done);
        chk("pulse_err", bus.sel_err, e.err);
        chk("pulse_cur", bus.cur_sel, e.cur);
      end
    end
`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
    if (to_flag) to_cnt++;
`endif
  endtask

  task automatic send(input logic [2:0] s);
    int   n = 0;
    logic acc;
    bus.sel_req   = s;
    bus.req_valid = 1'b1;
    do begin
      acc = bus.req_ready;
      tick();
      n++;
    end while (!acc && n < 400);
    bus.req_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !bus.req_ready) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_bound", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic track(input int ch);
    int mis = 0;
    repeat (3) begin
      tick();
      #2;
      repeat (9) begin
        if (clko !== clk_in[ch]) mis++;
        #10;
      end
    end
    chk("track", mis, 0);
  endtask

  initial begin
    vecs[0] = '{3'd2, 1'b0, 1'b1, 3'd2};
    vecs[1] = '{3'd2, 1'b0, 1'b1, 3'd2};
    vecs[2] = '{3'd5, 1'b1, 1'b0, 3'd2};
    vecs[3] = '{3'd7, 1'b1, 1'b0, 3'd2};
    vecs[4] = '{3'd4, 1'b0, 1'b1, 3'd4};
    vecs[5] = '{3'd0, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{3'd0, 1'b0, 1'b1, 3'd0};
    vecs[7] = '{3'd6, 1'b1, 1'b0, 3'd0};
    vecs[8] = '{3'd3, 1'b0, 1'b1, 3'd3};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.sel_req   = '0;
    repeat (3) @(posedge clk0_inv);
    #1;
    reset = 1'b0;

    chk("rst_ready", bus.req_ready, 1);
    chk("rst_done", bus.switch_done, 0);
    chk("rst_err", bus.sel_err, 0);
    chk("rst_cur", bus.cur_sel, 0);
    chk("rst_gate", dut.w_gate_en, 5'b00001);
    track(0);

    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{vecs[i].done, vecs[i].err, vecs[i].cur});
      send(vecs[i].sel);
      wait_idle();
      chk("cur_sel", bus.cur_sel, vecs[i].cur);
      track(int'(vecs[i].cur));
    end

    // Second request held valid through the whole busy period of the first.
    sb_q.push_back('{1'b1, 1'b0, 3'd1});
    sb_q.push_back('{1'b1, 1'b0, 3'd4});
    send(3'd1);
    chk("busy_after_accept", bus.req_ready, 0);
    send(3'd4);
    wait_idle();
    chk("held_cur", bus.cur_sel, 4);
    track(4);

    // Reset while the FSM sits in OFF.
    send(3'd2);
    chk("in_off_ready", bus.req_ready, 0);
    reset = 1'b1;
    #7;
    chk("midrst_cur", bus.cur_sel, 0);
    chk("midrst_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk0_inv);
    #1;
    reset = 1'b0;
    chk("postrst_gate", dut.w_gate_en, 5'b00001);
    chk("postrst_done", bus.switch_done, 0);
    track(0);

`ifdef GLITCH_FREE_NMUX_TIMEOUT_EN
    sb_q.push_back('{1'b1, 1'b0, 3'd1});
    send(3'd1);
    wait_idle();
    run1 = 1'b0;
    sb_q.push_back('{1'b1, 1'b0, 3'd3});
    send(3'd3);
    begin
      int n = 0;
      while (to_cnt == 0 && n < 1300) begin
        tick();
        n++;
      end
    end
    chk("timeout_seen", to_cnt, 1);
    wait_idle();
    chk("timeout_cur", bus.cur_sel, 3);
    track(3);
    chk("timeout_pulses", to_cnt, 1);
`endif

    chk("short_pulses", short_cnt, 0);
    chk("long_pulses", long_cnt, 0);
    chk("multi_gate", multi_cnt, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
